// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one Uart8 transmitter between NUM_REQ byte-stream requesters.
// Ownership is granted round-robin per packet: the owner keeps the UART
// until its byte flagged "last" has been sent, so packets never interleave.
// The block also runs the Uart8 handshake (tx_start pulse, wait for busy,
// wait for done) and aborts a byte if the UART never reports busy.

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ID_W         = 2,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [8*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  grant_valid,
    output logic [ID_W-1:0]       grant_id,
    output logic                  tx_en,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic                  err_timeout
);

    // Counter must be able to hold BUSY_TIMEOUT itself.
    localparam int CNT_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        ACK
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              last_q, last_d;
    logic              err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tx_en_q, tx_en_d;

    // View of the current owner's request lines
    logic              sel_valid;
    logic [7:0]        sel_data;
    logic              sel_last;

    // Result of the round-robin search
    logic              arb_found;
    logic [ID_W-1:0]   arb_id;

    // Pointer to the requester after the current owner, wrapping at NUM_REQ
    logic [ID_W-1:0]   rr_next;

    // Multiplex the granted requester's valid/data/last without indexing past NUM_REQ
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 8'h00;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[8*i +: 8];
                sel_last  = req_last[i];
            end
        end
    end

    // Search rr_ptr, rr_ptr+1, ... for the first valid requester; walking the
    // offsets downward lets the smallest offset win the final assignment
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                arb_found = 1'b1;
                arb_id    = ID_W'(idx);
            end
        end
    end

    // Next round-robin start point once the current owner releases the UART
    always_comb begin
        if (grant_id_q == ID_W'(NUM_REQ - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = grant_id_q + ID_W'(1);
        end
    end

    // Next-state and datapath updates for the arbitration / handshake FSM
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        last_d        = last_q;
        err_timeout_d = err_timeout_q;
        cnt_d         = cnt_q;
        tx_en_d       = 1'b1;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = ARB;
                end
            end

            ARB: begin
                if (arb_found) begin
                    grant_id_d    = arb_id;
                    grant_valid_d = 1'b1;
                    state_d       = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end

            LOAD: begin
                // A stalled owner keeps the lock; we simply wait here
                if (sel_valid) begin
                    tx_data_d = sel_data;
                    last_d    = sel_last;
                    state_d   = START;
                end
            end

            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q >= CNT_W'(BUSY_TIMEOUT)) begin
                    err_timeout_d = 1'b1;
                    state_d       = ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WAIT_DONE: begin
                // Busy dropping without a done pulse still ends the byte
                if (tx_done || !tx_busy) begin
                    state_d = ACK;
                end
            end

            ACK: begin
                if (last_q) begin
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = rr_next;
                    state_d       = IDLE;
                end else begin
                    state_d = LOAD;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            tx_data_q     <= 8'h00;
            last_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            cnt_q         <= '0;
            tx_en_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            tx_data_q     <= tx_data_d;
            last_q        <= last_d;
            err_timeout_q <= err_timeout_d;
            cnt_q         <= cnt_d;
            tx_en_q       <= tx_en_d;
        end
    end

    // Consume pulse goes only to the owner, and only while acknowledging
    always_comb begin
        req_ready = '0;
        if (state_q == ACK) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_id_q == ID_W'(i)) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    assign tx_start    = (state_q == START);
    assign tx_data     = tx_data_q;
    assign tx_en       = tx_en_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single Uart8 transmitter between NUM_REQ byte-stream requesters, e.g. Image_Sender pixel stream, status/ack responder and debug dump.
- Arbitrates round-robin at packet granularity: once granted, a requester keeps the UART until it sends a byte flagged last. Image frames are therefore never interleaved with other traffic.
- Sequences the Uart8 handshake itself: tx_en, tx_start pulse, wait for busy, wait for done.
- Sits between the requesters and Uart8 in the top level.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ID_W, 2, width of grant_id; must satisfy 2^ID_W >= NUM_REQ
BUSY_TIMEOUT, 1023, cycles to wait for tx_busy to rise after tx_start before aborting the byte

Ports:
clk  input  1  system clock (CLOCK_50)
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  requester i has a byte on req_data[8i+7:8i]
req_data  input  8*NUM_REQ  byte per requester
req_last  input  NUM_REQ  byte is final byte of requester's packet
req_ready  output  NUM_REQ  one-cycle pulse: requester's byte consumed by UART
grant_valid  output  1  a requester currently owns the UART
grant_id  output  ID_W  index of owning requester
tx_en  output  1  to Uart8 txEn
tx_start  output  1  to Uart8 txStart
tx_data  output  8  to Uart8 in
tx_busy  input  1  from Uart8 txBusy
tx_done  input  1  from Uart8 txDone
err_timeout  output  1  sticky: a byte was aborted on busy timeout

Behaviour:
- Async reset (rst=1): state=IDLE, rr_ptr=0, all outputs 0 (req_ready=0, grant_valid=0, grant_id=0, tx_en=0, tx_start=0, tx_data=0x00, err_timeout=0), timeout counter=0.
- tx_en=1 in every cycle after reset deasserts; err_timeout cleared only by rst.
- States: IDLE, ARB, LOAD, START, WAIT_BUSY, WAIT_DONE, ACK.
- IDLE: if any req_valid -> ARB.
- ARB: select first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Set grant_id=i, grant_valid=1 -> LOAD. If no valid by then -> IDLE.
- LOAD: register tx_data=req_data[grant_id], last_q=req_last[grant_id] -> START. If req_valid[grant_id] is low, stay in LOAD; the owner may stall mid-packet and the lock is kept.
- START: tx_start=1 for exactly one cycle, timeout counter cleared -> WAIT_BUSY.
- WAIT_BUSY: tx_busy=1 -> WAIT_DONE. If counter reaches BUSY_TIMEOUT first: set err_timeout, treat byte as consumed -> ACK.
- WAIT_DONE: tx_done=1 -> ACK. tx_busy falling without tx_done also -> ACK.
- ACK: req_ready[grant_id]=1 for one cycle. Then:
  - last_q=1: grant_valid=0, rr_ptr=(grant_id+1) mod NUM_REQ -> IDLE.
  - otherwise -> LOAD with same grant.
- tx_data holds its value from LOAD until the next LOAD, stable across the whole UART frame.
- At most one req_ready bit is high in any cycle; never high for a non-granted requester.
- Requesters must hold req_data/req_last stable while req_valid=1 until req_ready. Dropping req_valid before LOAD samples it stalls the arbiter in LOAD; it is not a protocol error.
- Per-byte latency, req_valid to tx_start, from IDLE: IDLE, ARB, LOAD, START = tx_start in 4th cycle. Within a packet: ACK, LOAD, START = 2 cycles after req_ready.
- Simultaneous requests resolved solely by the rr_ptr search order. A new request arriving during a packet waits until that packet's last byte is acked.
- Single-byte packet (req_last=1 on first byte) releases the grant after that byte.
- Reset mid-frame: FSM returns to IDLE immediately. The in-flight UART byte may still complete; tx_done/tx_busy in IDLE are ignored.
- NUM_REQ=2 wrap: rr_ptr toggles 0,1,0...

Test Plan:
- Single requester: req0 sends 0x41 (last=1), Uart8 model busy 10 cycles -> tx_start in 4th cycle with tx_data=0x41, req_ready[0] pulses once, grant_valid drops, rr_ptr=1.
- Contention: req0 and req2 valid same cycle, rr_ptr=0 -> req0 served first. Next ARB grants req2. After that, rr_ptr=0 and req1 is served before req2.
- Packet lock: req1 sends 3-byte packet 0x10,0x11,0x12 (last on 0x12) while req0 stays valid -> three tx_start pulses with grant_id=1 before any grant to req0.
- Mid-packet stall: req1 drops req_valid for 50 cycles after byte 1 -> arbiter stays in LOAD, grant_id=1, no tx_start, req0 not granted. Resume completes the packet.
- Busy timeout: UART model never raises tx_busy, BUSY_TIMEOUT=16 -> err_timeout=1 about 17 cycles after tx_start, req_ready pulses, next byte proceeds.
- Reset mid-frame: assert rst during WAIT_DONE -> all outputs 0 in the same cycle. After release, a stale tx_done produces no req_ready.
